// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Walks each instruction through FETCH..WB with wait-stated memories.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] npcctr,
    output logic       regwrite,
    output logic       regdst,
    output logic       alusrc,
    output logic [1:0] aluctr,
    output logic       memtoreg,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    // Counter needs at least one bit even when the timeout is disabled.
    localparam int CW  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int LIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
    localparam logic [CW-1:0] LIMV = LIM[CW-1:0];

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_ADDR,
        S_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t        state;
    state_t        nstate;
    logic [CW-1:0] cnt;
    logic [1:0]    cause_q;
    logic [1:0]    ncause;

    logic       is_r;
    logic       is_imm;
    logic       is_ld;
    logic       is_st;
    logic       is_beq;
    logic       is_j;
    logic       src_d;
    logic [1:0] ctr_d;
    logic       fn_ok;
    logic [1:0] fn_ctr;
    logic       waiting;
    logic       wait_hit;

    // Instruction class and ALU setting shared by EXEC, WB and the memory path.
    always_comb begin
        fn_ok  = 1'b1;
        fn_ctr = 2'b00;
        unique case (func)
            FN_ADD:  fn_ctr = 2'b00;
            FN_SUB:  fn_ctr = 2'b01;
            FN_AND:  fn_ctr = 2'b10;
            FN_OR:   fn_ctr = 2'b11;
            default: fn_ok  = 1'b0;
        endcase
        is_r   = (op == OP_R) && fn_ok;
        is_imm = (op == OP_ORI) || (op == OP_ADDI);
        is_ld  = (op == OP_LW);
        is_st  = (op == OP_SW);
        is_beq = (op == OP_BEQ);
        is_j   = (op == OP_J);
        src_d  = !is_r;
        ctr_d  = 2'b00;
        unique case (1'b1)
            is_r:             ctr_d = fn_ctr;
            (op == OP_ORI):   ctr_d = 2'b11;
            default:          ctr_d = 2'b00;
        endcase
    end

    assign waiting  = ((state == S_FETCH) && !imem_ready) ||
                      ((state == S_MEM) && !dmem_ready);
    assign wait_hit = (MAX_WAIT != 0) && (cnt == LIMV);

    // State, wait counter and trap cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cnt     <= '0;
            cause_q <= 2'b00;
        end else begin
            state   <= nstate;
            cause_q <= ncause;
            if (nstate != state)
                cnt <= '0;
            else if (waiting && (MAX_WAIT != 0))
                cnt <= cnt + CW'(1);
        end
    end

    // Next state and control strobes; everything forced low while in reset.
    always_comb begin
        nstate     = state;
        ncause     = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        npcctr     = 2'b00;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        alusrc     = 1'b0;
        aluctr     = 2'b00;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nstate  = S_DECODE;
                end else if (wait_hit) begin
                    nstate = S_TRAP;
                    ncause = 2'b10;
                end
            end
            S_DECODE: begin
                if (is_r || is_imm)
                    nstate = S_EXEC;
                else if (is_ld || is_st)
                    nstate = S_ADDR;
                else if (is_beq)
                    nstate = S_BRANCH;
                else if (is_j)
                    nstate = S_JUMP;
                else begin
                    nstate = S_TRAP;
                    ncause = 2'b01;
                end
            end
            S_EXEC: begin
                alusrc = src_d;
                aluctr = ctr_d;
                nstate = S_WB;
            end
            S_WB: begin
                regwrite   = 1'b1;
                regdst     = is_r;
                memtoreg   = is_ld;
                alusrc     = src_d;
                aluctr     = ctr_d;
                instr_done = 1'b1;
                nstate     = S_FETCH;
            end
            S_ADDR: begin
                alusrc = 1'b1;
                nstate = S_MEM;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                alusrc   = 1'b1;
                if (dmem_ready) begin
                    if (is_st) begin
                        instr_done = 1'b1;
                        nstate     = S_FETCH;
                    end else begin
                        nstate = S_WB;
                    end
                end else if (wait_hit) begin
                    nstate = S_TRAP;
                    ncause = 2'b11;
                end
            end
            S_BRANCH: begin
                aluctr     = 2'b01;
                instr_done = 1'b1;
                if (zero) begin
                    pcwrite = 1'b1;
                    npcctr  = 2'b01;
                end
                nstate = S_FETCH;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                npcctr     = 2'b10;
                instr_done = 1'b1;
                nstate     = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: nstate = S_FETCH;
        endcase
        if (!rst_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            npcctr     = 2'b00;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            alusrc     = 1'b0;
            aluctr     = 2'b00;
            memtoreg   = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MAX_WAIT=4).
// Each task drives a per-cycle table and checks the packed control word.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] npcctr;
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluctr;
    logic       memtoreg;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;

    logic [16:0] obs;
    int checks;
    int errors;

    logic [16:0] F_GO;
    logic [16:0] F_WT;
    logic [16:0] ADDRV;
    logic [16:0] MEMR;
    logic [16:0] MEMW;
    logic [16:0] T01;
    logic [16:0] T10;
    logic [16:0] T11;

    multicycle_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .func(func),
        .zero(zero),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req(imem_req),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .irwrite(irwrite),
        .pcwrite(pcwrite),
        .npcctr(npcctr),
        .regwrite(regwrite),
        .regdst(regdst),
        .alusrc(alusrc),
        .aluctr(aluctr),
        .memtoreg(memtoreg),
        .instr_done(instr_done),
        .trap(trap),
        .trap_cause(trap_cause)
    );

    assign obs = {imem_req, dmem_req, dmem_we, irwrite, pcwrite, npcctr,
                  regwrite, regdst, alusrc, aluctr, memtoreg,
                  instr_done, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ex(
        input logic ir, input logic dr, input logic we,
        input logic irw, input logic pcw, input logic [1:0] npc,
        input logic rw, input logic rd, input logic as,
        input logic [1:0] ac, input logic m2r, input logic dn,
        input logic tr, input logic [1:0] tc);
        return {ir, dr, we, irw, pcw, npc, rw, rd, as, ac, m2r, dn, tr, tc};
    endfunction

    task automatic step(input logic ir, input logic dr, input logic z);
        @(negedge clk);
        imem_ready = ir;
        dmem_ready = dr;
        zero       = z;
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        op         = 6'd0;
        func       = 6'd0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        zero       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== 17'h0) begin
                $display("FAIL reset c%0d got %05h exp %05h", i, obs, 17'h0);
                errors++;
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== F_WT) begin
            $display("FAIL reset_release got %05h exp %05h", obs, F_WT);
            errors++;
        end
    endtask

    task automatic test_rtype();
        logic [16:0] e [8];
        logic [5:0]  fn [8];
        logic        ir [8];
        do_reset();
        op = 6'b000000;
        fn = '{6'b100000, 6'b100000, 6'b100000, 6'b100000,
               6'b100010, 6'b100010, 6'b100010, 6'b100010};
        ir = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{F_GO, 17'h0, 17'h0,
               ex(0,0,0,0,0,2'b00,1,1,0,2'b00,0,1,0,2'b00),
               F_GO, 17'h0,
               ex(0,0,0,0,0,2'b00,0,0,0,2'b01,0,0,0,2'b00),
               ex(0,0,0,0,0,2'b00,1,1,0,2'b01,0,1,0,2'b00)};
        for (int i = 0; i < 8; i++) begin
            func = fn[i];
            step(ir[i], 1'b0, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL rtype c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_lw();
        logic [16:0] e [8];
        logic        dr [8];
        do_reset();
        op   = 6'b100011;
        func = 6'd0;
        dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e  = '{F_GO, 17'h0, ADDRV, MEMR, MEMR, MEMR, MEMR,
               ex(0,0,0,0,0,2'b00,1,0,1,2'b00,1,1,0,2'b00)};
        for (int i = 0; i < 8; i++) begin
            step(i == 0, dr[i], 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL lw c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_sw();
        logic [16:0] e [5];
        do_reset();
        op   = 6'b101011;
        func = 6'd0;
        e  = '{F_GO, 17'h0, ADDRV,
               ex(0,1,1,0,0,2'b00,0,0,1,2'b00,0,1,0,2'b00), F_WT};
        for (int i = 0; i < 5; i++) begin
            step(i == 0, i == 3, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL sw c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] e [6];
        logic        z [6];
        do_reset();
        op   = 6'b000100;
        func = 6'd0;
        z  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{F_GO, 17'h0,
               ex(0,0,0,0,1,2'b01,0,0,0,2'b01,0,1,0,2'b00),
               F_GO, 17'h0,
               ex(0,0,0,0,0,2'b00,0,0,0,2'b01,0,1,0,2'b00)};
        for (int i = 0; i < 6; i++) begin
            step(i == 0 || i == 3, 1'b0, z[i]);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL beq c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e [7];
        logic [5:0]  o [7];
        logic        ir [7];
        do_reset();
        func = 6'd0;
        o  = '{6'b000010, 6'b000010, 6'b000010,
               6'b001101, 6'b001101, 6'b001101, 6'b001101};
        ir = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{F_GO, 17'h0,
               ex(0,0,0,0,1,2'b10,0,0,0,2'b00,0,1,0,2'b00),
               F_GO, 17'h0,
               ex(0,0,0,0,0,2'b00,0,0,1,2'b11,0,0,0,2'b00),
               ex(0,0,0,0,0,2'b00,1,0,1,2'b11,0,1,0,2'b00)};
        for (int i = 0; i < 7; i++) begin
            op = o[i];
            step(ir[i], 1'b0, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL b2b c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e [4];
        logic [5:0]  o [2];
        logic [5:0]  fn [2];
        o  = '{6'b111111, 6'b000000};
        fn = '{6'b000000, 6'b101010};
        e  = '{F_GO, 17'h0, T01, T01};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            op   = o[k];
            func = fn[k];
            for (int i = 0; i < 4; i++) begin
                step(i != 1, 1'b1, 1'b0);
                checks++;
                if (obs !== e[i]) begin
                    $display("FAIL illegal%0d c%0d got %05h exp %05h",
                             k, i, obs, e[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_fetch_timeout();
        logic [16:0] e [6];
        logic [16:0] g [5];
        do_reset();
        op   = 6'b000000;
        func = 6'b100000;
        e = '{F_WT, F_WT, F_WT, F_WT, T10, T10};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL ftimeout c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
        do_reset();
        g = '{F_WT, F_WT, F_WT, F_GO, 17'h0};
        for (int i = 0; i < 5; i++) begin
            step(i == 3, 1'b0, 1'b0);
            checks++;
            if (obs !== g[i]) begin
                $display("FAIL fready_last c%0d got %05h exp %05h",
                         i, obs, g[i]);
                errors++;
            end
        end
    endtask

    task automatic test_mem_timeout();
        logic [16:0] e [8];
        do_reset();
        op   = 6'b100011;
        func = 6'd0;
        e = '{F_GO, 17'h0, ADDRV, MEMR, MEMR, MEMR, MEMR, T11};
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 1'b0, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL mtimeout c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [16:0] e [4];
        do_reset();
        op   = 6'b101011;
        func = 6'd0;
        e = '{F_GO, 17'h0, ADDRV, MEMW};
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 1'b0, 1'b0);
            checks++;
            if (obs !== e[i]) begin
                $display("FAIL rstmid c%0d got %05h exp %05h", i, obs, e[i]);
                errors++;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 17'h0) begin
            $display("FAIL rstmid_drop got %05h exp %05h", obs, 17'h0);
            errors++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== F_WT) begin
            $display("FAIL rstmid_fetch got %05h exp %05h", obs, F_WT);
            errors++;
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== F_GO) begin
            $display("FAIL rstmid_go got %05h exp %05h", obs, F_GO);
            errors++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        op         = 6'd0;
        func       = 6'd0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        F_GO  = ex(1,0,0,1,1,2'b00,0,0,0,2'b00,0,0,0,2'b00);
        F_WT  = ex(1,0,0,0,0,2'b00,0,0,0,2'b00,0,0,0,2'b00);
        ADDRV = ex(0,0,0,0,0,2'b00,0,0,1,2'b00,0,0,0,2'b00);
        MEMR  = ex(0,1,0,0,0,2'b00,0,0,1,2'b00,0,0,0,2'b00);
        MEMW  = ex(0,1,1,0,0,2'b00,0,0,1,2'b00,0,0,0,2'b00);
        T01   = ex(0,0,0,0,0,2'b00,0,0,0,2'b00,0,0,1,2'b01);
        T10   = ex(0,0,0,0,0,2'b00,0,0,0,2'b00,0,0,1,2'b10);
        T11   = ex(0,0,0,0,0,2'b00,0,0,0,2'b00,0,0,1,2'b11);
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
